// File: rtl/onix_breakout.sv
// ONIX breakout glue: LVDS command deserializer driving D_OUT/HARP, D_IN serializer, link status.
// Optional build macro LED_HEARTBEAT_EN makes the lock LED blink from a heartbeat counter.
`timescale 1ns/1ps
module onix_breakout #(
    parameter logic [11:0] SYNC_WORD = 12'h100,
    parameter logic [3:0]  TX_HDR    = 4'hA
) (
    input  logic       XTAL,
    input  logic       RST_N,
    input  logic [7:0] D_IN,
    input  logic [1:0] LVDS_IN,
    output logic [7:0] D_OUT,
    output logic [2:0] LVDS_OUT,
    inout  wire        I2C_SCL,
    inout  wire        I2C_SDA,
    output logic       HARP_CLK_OUT,
    output logic       LED,
    output logic       USBPU,
    output logic [3:0] link_status,
    output logic [3:0] link_led
);

    logic [1:0]  lvds_meta_q, lvds_meta_d;
    logic [1:0]  lvds_sync_q, lvds_sync_d;
    logic        strobe_prev_q, strobe_prev_d;
    logic [11:0] shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        locked_q, locked_d;
    logic        word_err_q, word_err_d;
    logic        rx_seen_q, rx_seen_d;
    logic        hunt_evt_q, hunt_evt_d;
    logic        word_evt_q, word_evt_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        harp_q, harp_d;
    logic        led_q, led_d;
    logic        tx_clk_q, tx_clk_d;
    logic [3:0]  tx_idx_q, tx_idx_d;
    logic [11:0] tx_word_q, tx_word_d;
    logic        tx_data_q, tx_data_d;
    logic        tx_frame_q, tx_frame_d;
    logic        bit_evt_s;

`ifdef LED_HEARTBEAT_EN
    localparam int HB_BITS = 23;
    logic [HB_BITS-1:0] hb_q, hb_d;
`endif

    assign bit_evt_s = lvds_sync_q[0] & ~strobe_prev_q;

    // Receive path: synchronize, shift on strobe edges, hunt for sync, decode words.
    always_comb begin
        lvds_meta_d   = LVDS_IN;
        lvds_sync_d   = lvds_meta_q;
        strobe_prev_d = lvds_sync_q[0];
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        locked_d      = locked_q;
        word_err_d    = word_err_q;
        rx_seen_d     = rx_seen_q;
        hunt_evt_d    = 1'b0;
        word_evt_d    = 1'b0;
        d_out_d       = d_out_q;
        harp_d        = harp_q;

        if (bit_evt_s) begin
            shreg_d   = {shreg_q[10:0], lvds_sync_q[1]};
            rx_seen_d = 1'b1;
            if (locked_q) begin
                word_evt_d = (bit_cnt_q == 4'd11);
                bit_cnt_d  = (bit_cnt_q == 4'd11) ? 4'd0 : bit_cnt_q + 4'd1;
            end else begin
                hunt_evt_d = 1'b1;
            end
        end else begin
            shreg_d = shreg_q;
        end

        // The compare runs one cycle after the shift so it sees the updated register.
        if (hunt_evt_q && (shreg_q == SYNC_WORD)) begin
            locked_d  = 1'b1;
            bit_cnt_d = 4'd0;
        end else begin
            locked_d = locked_q;
        end

        if (word_evt_q) begin
            case (shreg_q[11:8])
                4'd0: d_out_d = d_out_q;
                4'd1: d_out_d = shreg_q[7:0];
                4'd2: harp_d  = shreg_q[0];
                default: begin
                    word_err_d = 1'b1;
                    locked_d   = 1'b0;
                    bit_cnt_d  = 4'd0;
                end
            endcase
        end else begin
            d_out_d = d_out_q;
        end
    end

    // Transmit path: XTAL/2 bit clock, data and frame marker change on its falling edge.
    always_comb begin
        tx_clk_d   = ~tx_clk_q;
        tx_idx_d   = tx_idx_q;
        tx_word_d  = tx_word_q;
        tx_data_d  = tx_data_q;
        tx_frame_d = tx_frame_q;
        if (tx_clk_q) begin
            if (tx_idx_q == 4'd0) begin
                tx_idx_d   = 4'd11;
                tx_word_d  = {TX_HDR, D_IN};
                tx_data_d  = TX_HDR[3];
                tx_frame_d = 1'b1;
            end else begin
                tx_idx_d   = tx_idx_q - 4'd1;
                tx_data_d  = tx_word_q[tx_idx_q - 4'd1];
                tx_frame_d = 1'b0;
            end
        end else begin
            tx_idx_d = tx_idx_q;
        end
    end

`ifdef LED_HEARTBEAT_EN
    // Heartbeat counter gates the lock LED so it blinks while locked.
    always_comb begin
        hb_d  = hb_q + {{(HB_BITS-1){1'b0}}, 1'b1};
        led_d = locked_d & hb_d[HB_BITS-1];
    end
`else
    // Steady lock LED.
    always_comb begin
        led_d = locked_d;
    end
`endif

    // State registers for receive, transmit and LED logic.
    always_ff @(posedge XTAL or negedge RST_N) begin
        if (!RST_N) begin
            lvds_meta_q   <= 2'b00;
            lvds_sync_q   <= 2'b00;
            strobe_prev_q <= 1'b0;
            shreg_q       <= 12'h000;
            bit_cnt_q     <= 4'd0;
            locked_q      <= 1'b0;
            word_err_q    <= 1'b0;
            rx_seen_q     <= 1'b0;
            hunt_evt_q    <= 1'b0;
            word_evt_q    <= 1'b0;
            d_out_q       <= 8'h00;
            harp_q        <= 1'b0;
            led_q         <= 1'b0;
            tx_clk_q      <= 1'b0;
            tx_idx_q      <= 4'd0;
            tx_word_q     <= 12'h000;
            tx_data_q     <= 1'b0;
            tx_frame_q    <= 1'b0;
`ifdef LED_HEARTBEAT_EN
            hb_q          <= {HB_BITS{1'b0}};
`endif
        end else begin
            lvds_meta_q   <= lvds_meta_d;
            lvds_sync_q   <= lvds_sync_d;
            strobe_prev_q <= strobe_prev_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            locked_q      <= locked_d;
            word_err_q    <= word_err_d;
            rx_seen_q     <= rx_seen_d;
            hunt_evt_q    <= hunt_evt_d;
            word_evt_q    <= word_evt_d;
            d_out_q       <= d_out_d;
            harp_q        <= harp_d;
            led_q         <= led_d;
            tx_clk_q      <= tx_clk_d;
            tx_idx_q      <= tx_idx_d;
            tx_word_q     <= tx_word_d;
            tx_data_q     <= tx_data_d;
            tx_frame_q    <= tx_frame_d;
`ifdef LED_HEARTBEAT_EN
            hb_q          <= hb_d;
`endif
        end
    end

    assign D_OUT        = d_out_q;
    assign LVDS_OUT     = {tx_frame_q, tx_data_q, tx_clk_q};
    assign HARP_CLK_OUT = harp_q;
    assign LED          = led_q;
    assign USBPU        = 1'b0;
    assign link_status  = {1'b0, word_err_q, rx_seen_q, locked_q};
    assign link_led     = {1'b0, word_err_q, rx_seen_q, led_q};
    assign I2C_SCL      = 1'bz;
    assign I2C_SDA      = 1'bz;

endmodule

// File: tb/tb_onix_breakout.sv
// Self-checking bench for onix_breakout: directed link/TX steps plus random command words
// checked against a bit-stream reference model.
`timescale 1ns/1ps
module tb_onix_breakout;

    logic       xtal = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d_in;
    logic [1:0] lvds_in;
    wire  [7:0] d_out;
    wire  [2:0] lvds_out;
    wire        i2c_scl;
    wire        i2c_sda;
    wire        harp;
    wire        led;
    wire        usbpu;
    wire  [3:0] link_status;
    wire  [3:0] link_led;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [11:0] m_hist;
    logic        m_locked, m_err, m_seen, m_harp;
    logic [7:0]  m_dout;
    int          m_cnt;

    onix_breakout dut (
        .XTAL(xtal), .RST_N(rst_n), .D_IN(d_in), .LVDS_IN(lvds_in),
        .D_OUT(d_out), .LVDS_OUT(lvds_out), .I2C_SCL(i2c_scl), .I2C_SDA(i2c_sda),
        .HARP_CLK_OUT(harp), .LED(led), .USBPU(usbpu),
        .link_status(link_status), .link_led(link_led)
    );

    always #31 xtal = ~xtal;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = 12'h000; m_locked = 1'b0; m_err = 1'b0; m_seen = 1'b0;
        m_harp = 1'b0; m_dout = 8'h00; m_cnt = 0;
    endtask

    // One received bit as seen by the host protocol: hunt while unlocked, decode every 12th bit.
    task automatic model_bit(input logic b);
        m_hist = {m_hist[10:0], b};
        m_seen = 1'b1;
        if (!m_locked) begin
            if (m_hist == 12'h100) begin
                m_locked = 1'b1;
                m_cnt = 0;
            end
        end else if (m_cnt == 11) begin
            m_cnt = 0;
            if (m_hist[11:8] == 4'd1) m_dout = m_hist[7:0];
            else if (m_hist[11:8] == 4'd2) m_harp = m_hist[0];
            else if (m_hist[11:8] != 4'd0) begin
                m_err = 1'b1;
                m_locked = 1'b0;
            end
        end else begin
            m_cnt++;
        end
    endtask

    task automatic send_bit(input logic b);
        lvds_in[1] = b;
        lvds_in[0] = 1'b0;
        repeat (2) @(negedge xtal);
        lvds_in[0] = 1'b1;
        repeat (2) @(negedge xtal);
        model_bit(b);
    endtask

    task automatic send_word(input logic [11:0] w);
        for (int i = 11; i >= 0; i--) send_bit(w[i]);
        repeat (4) @(negedge xtal);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".d_out"}, {24'h0, d_out}, {24'h0, m_dout});
        check({tag, ".harp"}, {31'h0, harp}, {31'h0, m_harp});
        check({tag, ".status"}, {28'h0, link_status}, {28'h0, 1'b0, m_err, m_seen, m_locked});
        check({tag, ".led"}, {31'h0, led}, {31'h0, m_locked});
        check({tag, ".link_led"}, {28'h0, link_led}, {28'h0, 1'b0, m_err, m_seen, m_locked});
    endtask

    // Waits for a frame-marker rise, then samples data/marker at 12 TX-clock rising phases.
    task automatic capture_frame(input logic [11:0] exp_bits, input string tag);
        logic        prev_f;
        logic        found;
        logic [11:0] bits;
        logic [11:0] frm;
        prev_f = lvds_out[2];
        found = 1'b0;
        bits = 12'h000;
        frm = 12'h000;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge xtal);
            if (lvds_out[2] && !prev_f) found = 1'b1;
            else prev_f = lvds_out[2];
        end
        check({tag, ".found"}, {31'h0, found}, 32'h1);
        if (found) begin
            for (int k = 11; k >= 0; k--) begin
                @(negedge xtal);
                bits[k] = lvds_out[1];
                frm[k] = lvds_out[2];
                @(negedge xtal);
            end
            check({tag, ".bits"}, {20'h0, bits}, {20'h0, exp_bits});
            check({tag, ".marker"}, {20'h0, frm}, 32'h800);
            check({tag, ".period"}, {29'h0, lvds_out}, {29'h0, lvds_out[1], 2'b10});
        end
    endtask

    initial begin
        logic [11:0] w;
        logic [3:0]  cmd;
        int          r;
        d_in = 8'h3C;
        lvds_in = 2'b00;
        model_reset();
        repeat (3) @(negedge xtal);
        check("reset.lvds_out", {29'h0, lvds_out}, 32'h0);
        check("reset.d_out", {24'h0, d_out}, 32'h0);
        rst_n = 1'b1;

        // First frame begins on the second edge after release.
        @(negedge xtal);
        check("first.edge1", {29'h0, lvds_out}, 32'h1);
        @(negedge xtal);
        check("first.edge2", {29'h0, lvds_out}, 32'h6);

        repeat (14) @(negedge xtal);
        check("idle.usbpu", {31'h0, usbpu}, 32'h0);
        check_model("idle");

        capture_frame(12'hA3C, "tx3c");

        // Directed lock and command words.
        send_word(12'h100);
        check("lock.status", {28'h0, link_status}, 32'h3);
        check_model("lock");
        send_word(12'h1A5);
        check("dout.a5", {24'h0, d_out}, 32'hA5);
        check_model("cmd1");
        send_word(12'h201);
        check("harp.set", {31'h0, harp}, 32'h1);
        send_word(12'h200);
        check("harp.clr", {31'h0, harp}, 32'h0);
        send_word(12'hFFF);
        check("err.status", {28'h0, link_status}, 32'h6);
        check("err.d_out_hold", {24'h0, d_out}, 32'hA5);
        check_model("err");
        send_word(12'h100);
        check("relock.status", {28'h0, link_status}, 32'h7);
        check_model("relock");

        // Asynchronous reset in the middle of a word.
        for (int i = 11; i >= 7; i--) send_bit(1'b1);
        #7;
        rst_n = 1'b0;
        #1;
        check("arst.d_out", {24'h0, d_out}, 32'h0);
        check("arst.status", {28'h0, link_status}, 32'h0);
        check("arst.lvds_out", {29'h0, lvds_out}, 32'h0);
        check("arst.harp", {31'h0, harp}, 32'h0);
        lvds_in = 2'b00;
        model_reset();
        repeat (3) @(negedge xtal);
        rst_n = 1'b1;
        repeat (4) @(negedge xtal);
        send_word(12'h1A5);
        check("nolock.status", {28'h0, link_status}, 32'h2);
        check_model("nolock");
        send_word(12'h100);
        send_word(12'h15A);
        check("relock2.d_out", {24'h0, d_out}, 32'h5A);
        check_model("relock2");

        // Random command words against the model.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(99, 0);
            if (r < 45) cmd = 4'd1;
            else if (r < 65) cmd = 4'd2;
            else if (r < 80) cmd = 4'd0;
            else if (r < 88) cmd = 4'($urandom_range(15, 3));
            else cmd = 4'hF;
            w = {cmd, 8'($urandom_range(255, 0))};
            if (r >= 88 && r < 94) w = 12'h100;
            send_word(w);
            check_model("rand");
        end

        d_in = 8'($urandom_range(255, 0));
        capture_frame({4'hA, d_in}, "txrand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
